// File: rtl/ws2801_pkg.sv
// Shared types and helpers for the multi-channel WS2801 driver.
// Holds the FSM state set, wire colour orders and the byte reordering helper.
package ws2801_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ORD_RGB = 2'd0,
        ORD_RBG = 2'd1,
        ORD_GRB = 2'd2,
        ORD_BGR = 2'd3
    } order_t;

    localparam int LED_BITS = 24;

    // rgb is {R,G,B}; the result is the 24-bit word in the order it goes on the wire.
    function automatic logic [23:0] reorder(input logic [23:0] rgb, input order_t order);
        reorder = rgb;
        case (order)
            ORD_RGB: reorder = {rgb[23:16], rgb[15:8], rgb[7:0]};
            ORD_RBG: reorder = {rgb[23:16], rgb[7:0], rgb[15:8]};
            ORD_GRB: reorder = {rgb[15:8], rgb[23:16], rgb[7:0]};
            ORD_BGR: reorder = {rgb[7:0], rgb[15:8], rgb[23:16]};
            default: reorder = rgb;
        endcase
    endfunction

endpackage

// File: rtl/ws2801_scale.sv
// Combinational brightness scaling of a 24-bit LED word, byte by byte.
// Each byte becomes (v * (brightness + 1)) >> 8, so 255 is unity gain.
module ws2801_scale (
    input  logic [23:0] word,
    input  logic [7:0]  brightness,
    output logic [23:0] scaled
);

    logic [8:0]  gain;
    logic [15:0] prod;

    assign gain = {1'b0, brightness} + 9'd1;

    always_comb begin
        scaled = '0;
        prod   = '0;
        for (int k = 0; k < 3; k++) begin
            prod = 16'(word[8*k +: 8]) * 16'(gain);
            scaled[8*k +: 8] = 8'(prod >> 8);
        end
    end

endmodule

// File: rtl/ws2801_multi_driver.sv
// Drives CHANNELS WS2801 strips in lock-step from a snapshot of the frame.
// Serial clock is divided internally; a latch gap follows every frame.
module ws2801_multi_driver
    import ws2801_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int LEDS         = 50,
    parameter int DIV          = 32,
    parameter int LATCH_CYCLES = 40000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             continuous,
    input  logic [7:0]                       brightness,
    input  logic [1:0]                       color_order,
    input  logic [CHANNELS*LEDS*LED_BITS-1:0] led_rgb,
    output logic [CHANNELS-1:0]              dOut,
    output logic [CHANNELS-1:0]              clkOut,
    output logic                             busy,
    output logic                             done
);

    localparam int FRAME_W = CHANNELS * LEDS * LED_BITS;
    localparam int IW      = $clog2(FRAME_W);
    localparam int LW      = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(LATCH_CYCLES + 1);

    state_t               state;
    logic [FRAME_W-1:0]   snap_rgb;
    logic [7:0]           snap_bright;
    order_t               snap_order;
    logic [4:0]           bit_idx;
    logic [LW-1:0]        led_idx;
    logic [PW-1:0]        phase;
    logic [CW-1:0]        latch_cnt;
    logic                 high;

    logic [FRAME_W-1:0]   src_rgb;
    logic [7:0]           src_bright;
    order_t               src_order;
    logic [LW-1:0]        word_led;
    logic [4:0]           nxt_pos;
    logic [CHANNELS-1:0]  nxt_d;
    logic                 last_led;

    assign last_led = (led_idx == LW'(LEDS - 1));

    // Outside SHIFT the scaler looks at the live inputs so the first bit can
    // be registered on the same edge that takes the snapshot.
    always_comb begin
        src_rgb    = led_rgb;
        src_bright = brightness;
        src_order  = order_t'(color_order);
        word_led   = '0;
        nxt_pos    = 5'd23;
        if (state == SHIFT) begin
            src_rgb    = snap_rgb;
            src_bright = snap_bright;
            src_order  = snap_order;
            if (bit_idx == 5'd0) begin
                word_led = last_led ? led_idx : led_idx + LW'(1);
            end else begin
                word_led = led_idx;
                nxt_pos  = bit_idx - 5'd1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [IW-1:0]  base;
        logic [23:0]    wire_word;
        logic [23:0]    scaled;

        assign base      = IW'((c * LEDS + int'(word_led)) * LED_BITS);
        assign wire_word = reorder(src_rgb[base +: LED_BITS], src_order);

        ws2801_scale u_scale (
            .word       (wire_word),
            .brightness (src_bright),
            .scaled     (scaled)
        );

        assign nxt_d[c] = scaled[nxt_pos];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            snap_rgb    <= '0;
            snap_bright <= '0;
            snap_order  <= ORD_RGB;
            bit_idx     <= '0;
            led_idx     <= '0;
            phase       <= '0;
            latch_cnt   <= '0;
            high        <= 1'b0;
            dOut        <= '0;
            clkOut      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        snap_rgb    <= led_rgb;
                        snap_bright <= brightness;
                        snap_order  <= order_t'(color_order);
                        busy        <= 1'b1;
                        state       <= SHIFT;
                        bit_idx     <= 5'd23;
                        led_idx     <= '0;
                        phase       <= PW'(DIV - 1);
                        high        <= 1'b0;
                        clkOut      <= '0;
                        dOut        <= nxt_d;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (phase != '0) begin
                        phase <= phase - PW'(1);
                    end else if (!high) begin
                        high   <= 1'b1;
                        clkOut <= '1;
                        phase  <= PW'(DIV - 1);
                    end else if (bit_idx == 5'd0 && last_led) begin
                        state     <= LATCH;
                        high      <= 1'b0;
                        clkOut    <= '0;
                        dOut      <= '0;
                        latch_cnt <= CW'(LATCH_CYCLES - 1);
                    end else begin
                        high   <= 1'b0;
                        clkOut <= '0;
                        dOut   <= nxt_d;
                        phase  <= PW'(DIV - 1);
                        if (bit_idx == 5'd0) begin
                            bit_idx <= 5'd23;
                            led_idx <= led_idx + LW'(1);
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt != '0) begin
                        latch_cnt <= latch_cnt - CW'(1);
                    end else begin
                        done  <= 1'b1;
                        busy  <= continuous;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2801_multi_driver.sv
// Scoreboard bench for ws2801_multi_driver: expected bit streams and done
// cycles are queued at stimulus time and consumed by a negedge monitor.
module tb_ws2801_multi_driver;

    localparam int CH   = 2;
    localparam int LEDS = 2;
    localparam int DIV  = 2;
    localparam int LAT  = 10;
    localparam int T    = LEDS * 48 * DIV + LAT;
    localparam int FW   = CH * LEDS * 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [7:0]    brightness = 8'd255;
    logic [1:0]    color_order = 2'd0;
    logic [FW-1:0] led_rgb = '0;
    logic [CH-1:0] dOut;
    logic [CH-1:0] clkOut;
    logic          busy;
    logic          done;

    ws2801_multi_driver #(
        .CHANNELS     (CH),
        .LEDS         (LEDS),
        .DIV          (DIV),
        .LATCH_CYCLES (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .brightness  (brightness),
        .color_order (color_order),
        .led_rgb     (led_rgb),
        .dOut        (dOut),
        .clkOut      (clkOut),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [CH-1:0] bitq[$];
    int            doneq[$];
    bit            mon_en = 1'b1;
    logic [CH-1:0] clk_prev = '0;
    logic [CH-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_word(input logic [23:0] rgb, input int b, input int ord);
        logic [7:0] rs, gs, bs;
        rs = 8'((int'(rgb[23:16]) * (b + 1)) >> 8);
        gs = 8'((int'(rgb[15:8])  * (b + 1)) >> 8);
        bs = 8'((int'(rgb[7:0])   * (b + 1)) >> 8);
        case (ord)
            0:       return {rs, gs, bs};
            1:       return {rs, bs, gs};
            2:       return {gs, rs, bs};
            default: return {bs, gs, rs};
        endcase
    endfunction

    task automatic push_frame(input logic [FW-1:0] frame, input int b, input int ord, input int done_at);
        logic [CH-1:0] v;
        logic [23:0]   w;
        for (int i = 0; i < LEDS; i++) begin
            for (int k = 23; k >= 0; k--) begin
                for (int c = 0; c < CH; c++) begin
                    w = exp_word(frame[(c*LEDS+i)*24 +: 24], b, ord);
                    v[c] = w[k];
                end
                bitq.push_back(v);
            end
        end
        doneq.push_back(done_at);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Starts one frame with a single-cycle start pulse and checks the busy window.
    task automatic run_frame();
        int n;
        @(negedge clk);
        n = cyc;
        push_frame(led_rgb, int'(brightness), int'(color_order), n + 1 + T);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_first", busy, 1);
        wait_until(n + T);
        check("busy_last", busy, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        check("done_queue_drained", doneq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (clkOut[0] && !clk_prev[0]) begin
                check("clk_channels_equal", clkOut[1], clkOut[0]);
                if (bitq.size() == 0) begin
                    check("unexpected_clk_rise", clkOut[0], 0);
                end else begin
                    mon_exp = bitq.pop_front();
                    check("dout_bit", dOut, mon_exp);
                end
            end
            if (done) begin
                if (doneq.size() == 0) check("unexpected_done", done, 0);
                else check("done_cycle", cyc, doneq.pop_front());
            end
        end
        clk_prev = clkOut;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_dout", dOut, 0);
        check("rst_clkout", clkOut, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame, unity brightness, RGB order; channel 1 carries other data.
        led_rgb = {24'h123456, 24'hA5C33C, 24'h00FF00, 24'h800001};
        run_frame();

        // GRB wire order, then half brightness.
        color_order = 2'd2;
        run_frame();
        color_order = 2'd0;
        brightness  = 8'd127;
        run_frame();
        brightness  = 8'd0;
        run_frame();

        // RBG order at brightness 200.
        brightness  = 8'd200;
        color_order = 2'd1;
        run_frame();

        // Snapshot isolation and start-while-busy ignored (BGR order).
        brightness  = 8'd255;
        color_order = 2'd3;
        led_rgb     = {24'hF0E1D2, 24'h0F1E2D, 24'hC3A5FF, 24'h13579B};
        @(negedge clk);
        n = cyc;
        push_frame(led_rgb, 255, 3, n + 1 + T);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(n + 5);
        led_rgb = ~led_rgb;
        brightness = 8'd10;
        wait_until(n + 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(n + 1 + T);
        check("snap_busy_after_done", busy, 0);
        repeat (20) @(negedge clk);
        check("no_requeued_frame", busy, 0);
        brightness  = 8'd255;
        color_order = 2'd0;

        // Continuous mode: two frames back to back, second picks up new data.
        led_rgb = {24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        @(negedge clk);
        n = cyc;
        push_frame(led_rgb, 255, 0, n + 1 + T);
        continuous = 1'b1;
        wait_until(n + 5);
        led_rgb = {24'hAABBCC, 24'hDDEEFF, 24'h112233, 24'h445566};
        push_frame(led_rgb, 255, 0, n + 2 + 2 * T);
        wait_until(n + 1 + T);
        check("cont_busy_held", busy, 1);
        wait_until(n + T + 20);
        continuous = 1'b0;
        wait_until(n + 2 + 2 * T);
        check("cont_busy_released", busy, 0);
        repeat (20) @(negedge clk);
        check("cont_stopped", busy, 0);
        check("cont_done_queue", doneq.size(), 0);

        // Asynchronous reset in the middle of SHIFT, then a clean frame.
        mon_en  = 1'b0;
        led_rgb = '1;
        @(negedge clk);
        n = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(n + 30);
        @(posedge clk);
        #2;
        check("pre_rst_clkout", clkOut, 2'b11);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_dout", dOut, 0);
        check("async_rst_clkout", clkOut, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bitq.delete();
        doneq.delete();
        @(negedge clk);
        mon_en  = 1'b1;
        led_rgb = {24'h123456, 24'hA5C33C, 24'h00FF00, 24'h800001};
        run_frame();

        check("bit_queue_empty", bitq.size(), 0);
        check("done_queue_empty", doneq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
